// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the single-port RAM with init sweep.
package sync_ram_pkg;

  // Controller states: sweeping INIT_VALUE into the array, or serving accesses.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_init_state_e;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned bytes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/sync_ram_init_ctrl.sv
// Init sweep controller: walks the array writing the init value, then grants accesses.
module sync_ram_init_ctrl
  import sync_ram_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned INIT_EN    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_init,
  output logic             o_gnt,
  output logic             o_init_done,
  output logic             o_sweep_we,
  output logic [CNT_W-1:0] o_sweep_addr
);

  localparam ram_init_state_e RESET_STATE = (INIT_EN != 0) ? INIT : READY;
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(DATA_DEPTH - 1);

  ram_init_state_e  r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  // Next-state: sweep one address per cycle, re-arm on an init request while ready.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      INIT: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_next = READY;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      READY: begin
        if ((INIT_EN != 0) && i_init) begin
          w_state_next = INIT;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Gated by reset so grant and done read 0 while reset is held, even without a sweep.
  assign o_gnt        = (r_state == READY) && i_rst_n;
  assign o_init_done  = (r_state == READY) && i_rst_n;
  assign o_sweep_we   = (r_state == INIT) && i_rst_n;
  assign o_sweep_addr = r_cnt;

endmodule

// File: rtl/sync_sp_ram_be_init.sv
// Synchronous single-port RAM with byte enables, post-reset init sweep, grant,
// read-valid tracking and out-of-range detection.
module sync_sp_ram_be_init
  import sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic                    Init_SI,
  input  logic                    CSel_SI,
  input  logic                    WrEn_SI,
  input  logic [DATA_WIDTH/8-1:0] BEn_SI,
  input  logic [DATA_WIDTH-1:0]   WrData_DI,
  input  logic [ADDR_WIDTH-1:0]   Addr_DI,
  output logic                    Gnt_SO,
  output logic [DATA_WIDTH-1:0]   RdData_DO,
  output logic                    RdValid_SO,
  output logic                    AddrErr_SO,
  output logic                    InitDone_SO
);

  localparam int unsigned NB    = bytes(DATA_WIDTH);
  localparam int unsigned IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  if ((64'd1 << ADDR_WIDTH) < 64'(DATA_DEPTH)) begin : g_chk_addr
    $error("ADDR_WIDTH too small for DATA_DEPTH");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_chk_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

  logic                  w_gnt;
  logic                  w_sweep_we;
  logic [IDX_W-1:0]      w_sweep_addr;
  logic                  w_in_range;
  logic                  w_rd_acc, w_wr_acc;
  logic                  w_mem_we, w_mem_re;
  logic [NB-1:0]         w_mem_be;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [IDX_W-1:0]      w_mem_idx;
  logic [DATA_WIDTH-1:0] r_mem_rdata;

  sync_ram_init_ctrl #(
    .CNT_W      (IDX_W),
    .DATA_DEPTH (DATA_DEPTH),
    .INIT_EN    (INIT_EN)
  ) u_ctrl (
    .i_clk        (Clk_CI),
    .i_rst_n      (Rst_RBI),
    .i_init       (Init_SI),
    .o_gnt        (w_gnt),
    .o_init_done  (InitDone_SO),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_addr (w_sweep_addr)
  );

  assign Gnt_SO     = w_gnt;
  assign w_in_range = ({1'b0, Addr_DI} < DEPTH_L);
  assign w_wr_acc   = CSel_SI & w_gnt & WrEn_SI;
  assign w_rd_acc   = CSel_SI & w_gnt & ~WrEn_SI;
  assign w_mem_re   = w_rd_acc & w_in_range;

  // Write-port mux: the sweep owns the array while granting is off.
  always_comb begin
    if (w_sweep_we) begin
      w_mem_we    = 1'b1;
      w_mem_be    = '1;
      w_mem_wdata = INIT_VALUE;
      w_mem_idx   = w_sweep_addr;
    end else begin
      w_mem_we    = w_wr_acc & w_in_range;
      w_mem_be    = BEn_SI;
      w_mem_wdata = WrData_DI;
      w_mem_idx   = Addr_DI[IDX_W-1:0];
    end
  end

`ifdef FPGA_TARGET_ALTERA
  logic [NB-1:0][7:0] r_mem [DATA_DEPTH];

  // Byte-lane array for Quartus byte-enable inference; no reset so it maps to block RAM.
  always_ff @(posedge Clk_CI) begin
    for (int i = 0; i < NB; i++) begin
      if (w_mem_we && w_mem_be[i]) r_mem[w_mem_idx][i] <= w_mem_wdata[8*i +: 8];
    end
    if (w_mem_re) r_mem_rdata <= r_mem[w_mem_idx];
  end
`else
  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  // Flat-word array with per-lane writes for Vivado; no reset so it maps to block RAM.
  always_ff @(posedge Clk_CI) begin
    for (int i = 0; i < NB; i++) begin
      if (w_mem_we && w_mem_be[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
    end
    if (w_mem_re) r_mem_rdata <= r_mem[w_mem_idx];
  end
`endif

  logic                  r_rd_v1, r_rd_oor1, r_rd_seen, r_wr_err1;
  logic [DATA_WIDTH-1:0] w_rd_data1;
  logic                  w_rd_err1;
  logic                  w_rd_valid, w_rd_err;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // First pipeline stage: read valid, out-of-range flags and write error pulse.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_rd_v1   <= 1'b0;
      r_rd_oor1 <= 1'b0;
      r_rd_seen <= 1'b0;
      r_wr_err1 <= 1'b0;
    end else begin
      r_rd_v1   <= w_rd_acc;
      r_wr_err1 <= w_wr_acc & ~w_in_range;
      if (w_rd_acc) begin
        r_rd_oor1 <= ~w_in_range;
        r_rd_seen <= 1'b1;
      end
    end
  end

  // The array read register is unreset, so mask it to zero until a read lands.
  assign w_rd_data1 = (r_rd_seen && !r_rd_oor1) ? r_mem_rdata : '0;
  assign w_rd_err1  = r_rd_v1 & r_rd_oor1;

  if (OUT_REGS != 0) begin : g_out_regs
    logic                  r_rd_v2, r_rd_err2;
    logic [DATA_WIDTH-1:0] r_rd_data2;

    // Optional output stage; data captured only on valid so it holds between reads.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
        r_rd_v2    <= 1'b0;
        r_rd_err2  <= 1'b0;
        r_rd_data2 <= '0;
      end else begin
        r_rd_v2   <= r_rd_v1;
        r_rd_err2 <= w_rd_err1;
        if (r_rd_v1) r_rd_data2 <= w_rd_data1;
      end
    end

    assign w_rd_valid = r_rd_v2;
    assign w_rd_err   = r_rd_err2;
    assign w_rd_data  = r_rd_data2;
  end else begin : g_no_out_regs
    assign w_rd_valid = r_rd_v1;
    assign w_rd_err   = w_rd_err1;
    assign w_rd_data  = w_rd_data1;
  end

  assign RdValid_SO = w_rd_valid;
  assign RdData_DO  = w_rd_data;
  // Write errors always report one cycle after accept, whatever the read latency.
  assign AddrErr_SO = w_rd_err | r_wr_err1;

endmodule

// File: tb/tb_sync_sp_ram_be_init.sv
// Scoreboard bench: random and directed accesses against a word-array reference model.
module tb_sync_sp_ram_be_init;

  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam logic [DW-1:0] IV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          init = 1'b0, csel = 1'b0, we = 1'b0;
  logic [NB-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] addr = '0;

  logic          gnt0, rv0, err0, done0;
  logic          gnt1, rv1, err1, done1;
  logic          gnt2, rv2, err2, done2;
  logic [DW-1:0] rdata0, rdata1, rdata2;

  sync_sp_ram_be_init #(
    .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW),
    .OUT_REGS(0), .INIT_EN(1), .INIT_VALUE(IV)
  ) u_dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Init_SI(init), .CSel_SI(csel), .WrEn_SI(we),
    .BEn_SI(be), .WrData_DI(wdata), .Addr_DI(addr), .Gnt_SO(gnt0), .RdData_DO(rdata0),
    .RdValid_SO(rv0), .AddrErr_SO(err0), .InitDone_SO(done0)
  );

  sync_sp_ram_be_init #(
    .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW),
    .OUT_REGS(1), .INIT_EN(1), .INIT_VALUE(IV)
  ) u_dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Init_SI(init), .CSel_SI(csel), .WrEn_SI(we),
    .BEn_SI(be), .WrData_DI(wdata), .Addr_DI(addr), .Gnt_SO(gnt1), .RdData_DO(rdata1),
    .RdValid_SO(rv1), .AddrErr_SO(err1), .InitDone_SO(done1)
  );

  // No sweep: grant must be up from the first cycle after reset and ignore Init_SI.
  sync_sp_ram_be_init #(
    .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW),
    .OUT_REGS(0), .INIT_EN(0), .INIT_VALUE(IV)
  ) u_dut2 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Init_SI(init), .CSel_SI(1'b0), .WrEn_SI(1'b0),
    .BEn_SI('0), .WrData_DI('0), .Addr_DI('0), .Gnt_SO(gnt2), .RdData_DO(rdata2),
    .RdValid_SO(rv2), .AddrErr_SO(err2), .InitDone_SO(done2)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t          rd_q [2][$];
  int            werr_q [2][$];
  logic [DW-1:0] last_data [2];
  logic [DW-1:0] mem [DEPTH];
  int            sweep_left = 0;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Pops expected read responses when the DUT presents valid; checks hold and error pulses.
  task automatic mon(input int d, input logic v, input logic e, input logic [DW-1:0] dat);
    logic exp_err;
    exp_t x;
    exp_err = 1'b0;
    if (werr_q[d].size() > 0 && werr_q[d][0] == cyc) begin
      void'(werr_q[d].pop_front());
      exp_err = 1'b1;
    end
    if (v) begin
      if (rd_q[d].size() == 0) begin
        flag($sformatf("dut%0d RdValid with no pending read", d));
      end else begin
        x = rd_q[d].pop_front();
        chk($sformatf("dut%0d read data", d), 64'(dat), 64'(x.data));
        chk($sformatf("dut%0d read latency", d), 64'(cyc), 64'(x.due));
        exp_err |= x.err;
        last_data[d] = x.data;
      end
    end else begin
      if (rd_q[d].size() > 0 && rd_q[d][0].due <= cyc) begin
        flag($sformatf("dut%0d missing RdValid", d));
        void'(rd_q[d].pop_front());
      end
      chk($sformatf("dut%0d RdData hold", d), 64'(dat), 64'(last_data[d]));
    end
    chk($sformatf("dut%0d AddrErr", d), 64'(e), 64'(exp_err));
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, rv0, err0, rdata0);
      mon(1, rv1, err1, rdata1);
    end
  end

  // One bus cycle: check grant, predict the response, advance the model past the edge.
  task automatic do_cycle(input logic c, input logic w, input logic [NB-1:0] b,
                          input logic [DW-1:0] d, input logic [AW-1:0] a, input logic i);
    logic ready, start;
    exp_t x;
    csel = c; we = w; be = b; wdata = d; addr = a; init = i;
    ready = (sweep_left == 0);
    start = 1'b0;
    chk("dut0 Gnt", 64'(gnt0), 64'(ready));
    chk("dut0 InitDone", 64'(done0), 64'(ready));
    chk("dut1 Gnt", 64'(gnt1), 64'(ready));
    chk("dut2 Gnt", 64'(gnt2), 64'd1);
    chk("dut2 InitDone", 64'(done2), 64'd1);
    if (c && ready) begin
      if (!w) begin
        x.data = (int'(a) < DEPTH) ? mem[int'(a)] : '0;
        x.err  = !(int'(a) < DEPTH);
        x.due  = cyc + 1;
        rd_q[0].push_back(x);
        x.due  = cyc + 2;
        rd_q[1].push_back(x);
      end else if (int'(a) < DEPTH) begin
        for (int k = 0; k < NB; k++) if (b[k]) mem[int'(a)][8*k +: 8] = d[8*k +: 8];
      end else begin
        werr_q[0].push_back(cyc + 1);
        werr_q[1].push_back(cyc + 1);
      end
    end
    if (i && ready) start = 1'b1;
    @(posedge clk);
    #1;
    if (sweep_left > 0) sweep_left--;
    if (start) begin
      sweep_left = DEPTH;
      for (int k = 0; k < DEPTH; k++) mem[k] = IV;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear at once; pending reads are discarded.
  task automatic do_reset(input int hold);
    csel = 1'b0;
    init = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst dut0 Gnt", 64'(gnt0), 64'd0);
    chk("rst dut0 InitDone", 64'(done0), 64'd0);
    chk("rst dut0 RdValid", 64'(rv0), 64'd0);
    chk("rst dut0 AddrErr", 64'(err0), 64'd0);
    chk("rst dut0 RdData", 64'(rdata0), 64'd0);
    chk("rst dut1 RdValid", 64'(rv1), 64'd0);
    chk("rst dut1 RdData", 64'(rdata1), 64'd0);
    chk("rst dut2 Gnt", 64'(gnt2), 64'd0);
    chk("rst dut2 InitDone", 64'(done2), 64'd0);
    for (int k = 0; k < 2; k++) begin
      rd_q[k].delete();
      werr_q[k].delete();
      last_data[k] = '0;
    end
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_left = DEPTH;
    for (int k = 0; k < DEPTH; k++) mem[k] = IV;
    #1;
    chk("dut2 Gnt after release", 64'(gnt2), 64'd1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);
    mon_on = 1'b1;

    // Sweep, then every word reads back as the init value.
    idle(DEPTH);
    for (int k = 0; k < DEPTH; k++) do_cycle(1'b1, 1'b0, '0, '0, AW'(k), 1'b0);

    // Partial byte write then read-after-write.
    do_cycle(1'b1, 1'b1, 4'b0101, 32'h11223344, 5'd3, 1'b0);
    do_cycle(1'b1, 1'b0, '0, '0, 5'd3, 1'b0);

    // Back-to-back writes and reads.
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b1, 4'hF, DW'(k + 1), AW'(k), 1'b0);
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0, '0, '0, AW'(k), 1'b0);
    do_cycle(1'b1, 1'b1, 4'h0, 32'hDEADBEEF, 5'd2, 1'b0);
    do_cycle(1'b1, 1'b0, '0, '0, 5'd2, 1'b0);

    // Out-of-range read and write; address 17 must not alias onto address 1.
    do_cycle(1'b1, 1'b0, '0, '0, 5'd20, 1'b0);
    do_cycle(1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 5'd17, 1'b0);
    idle(1);
    do_cycle(1'b1, 1'b0, '0, '0, 5'd1, 1'b0);
    idle(2);

    // Init request together with a read: the read sees pre-sweep data.
    do_cycle(1'b1, 1'b0, '0, '0, 5'd3, 1'b1);
    idle(DEPTH);
    do_cycle(1'b1, 1'b0, '0, '0, 5'd3, 1'b0);

    // Reset in the middle of a sweep restarts it from scratch.
    do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(7);
    do_reset(2);
    idle(DEPTH);

    // Reset while reads are still in flight.
    do_cycle(1'b1, 1'b0, '0, '0, 5'd5, 1'b0);
    do_reset(1);
    idle(DEPTH);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      do_cycle(($urandom % 10) < 7, 1'($urandom % 2), NB'($urandom), DW'($urandom),
               AW'($urandom_range(0, 19)), ($urandom % 50) == 0);
    end
    idle(4);
    chk("dut0 reads drained", 64'(rd_q[0].size()), 64'd0);
    chk("dut1 reads drained", 64'(rd_q[1].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
